periodic_rst_seq: RTL and testbench



---
 rtl/periodic_rst_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/periodic_rst_seq.sv | 164 ++++++++++++++++
 tb/tb_periodic_rst_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/periodic_rst_pkg.sv
// rtl/periodic_rst_pkg.sv - shared state type, widths and elaboration helper for periodic_rst_seq
package periodic_rst_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int unsigned CYCLE_CNT_W = 16;

  // True when value is representable in an unsigned counter of the given width.
  function automatic bit fits_cnt_w(longint unsigned value, int unsigned width);
    if (width >= 64) return 1'b1;
    return (value >> width) == 64'd0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - PRESCALE-cycle tick strobe with synchronous clear and advance gate
module tick_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic adv_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = adv_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/periodic_rst_seq.sv
// rtl/periodic_rst_seq.sv - periodic staggered reset sequencer with trigger, enable, LED and counter
// Optional watchdog: define PERIODIC_RST_WDOG_EN.
module periodic_rst_seq
  import periodic_rst_pkg::*;
#(
  parameter int unsigned PRESCALE      = 100,
  parameter int unsigned PERIOD_TICKS  = 60000000,
  parameter int unsigned PULSE_TICKS   = 500000,
  parameter int unsigned N_CH          = 2,
  parameter int unsigned STAGGER_TICKS = 1000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en_in,
  input  logic                   trig_in,
  input  logic                   kick_in,
  output logic [N_CH-1:0]        rst_out,
  output logic                   busy_out,
  output logic                   led_out,
  output logic [CYCLE_CNT_W-1:0] cycle_cnt_out,
  output logic                   wdog_fired_out
);

  localparam int unsigned LAST_REL = (N_CH - 1) * STAGGER_TICKS;
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(LAST_REL - 1);

  if (PRESCALE < 1 || PERIOD_TICKS < 1 || PULSE_TICKS < 1 || N_CH < 1 ||
      !fits_cnt_w(longint'(PERIOD_TICKS), CNT_W) ||
      !fits_cnt_w(longint'(PULSE_TICKS), CNT_W) ||
      !fits_cnt_w(longint'(N_CH - 1) * longint'(STAGGER_TICKS), CNT_W)) begin : g_param_check
    $error("periodic_rst_seq: parameter out of range for CNT_W");
  end

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_CH-1:0]         rst_q, rst_d;
  logic [CYCLE_CNT_W-1:0]  cyc_q, cyc_d;
  logic                    led_q;
  logic                    tick;
  logic                    wd_expire;

  // The prescaler freezes while RUN is disabled so the period count truly pauses.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .clr_i  (state_d != state_q),
    .adv_i  ((state_q != RUN) || en_in),
    .tick_o (tick)
  );

`ifdef PERIODIC_RST_WDOG_EN
  localparam int unsigned WDOG_TICKS = PERIOD_TICKS / 4;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_TICKS - 1);

  logic [CNT_W-1:0] wd_q, wd_d;
  logic             fired_q;

  always_comb begin
    wd_d      = wd_q;
    wd_expire = 1'b0;
    if (state_q != RUN || kick_in) begin
      wd_d = '0;
    end else if (tick) begin
      if (wd_q == WDOG_LAST) wd_expire = 1'b1;
      else                   wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wd_q    <= '0;
      fired_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (state_q == RUN && !trig_in && wd_expire) fired_q <= 1'b1;
    end
  end

  assign wdog_fired_out = fired_q;
`else
  logic unused_kick;
  assign unused_kick    = kick_in;
  assign wd_expire      = 1'b0;
  assign wdog_fired_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      ASSERT: if (tick) begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          if (LAST_REL == 0) begin
            state_d = RUN;
            rst_d   = '0;
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
          end else begin
            state_d  = RELEASE;
            rst_d[0] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: if (tick) begin
        // Channel k drops on the tick that completes k*STAGGER_TICKS ticks of RELEASE.
        for (int k = 1; k < N_CH; k++) begin
          if (cnt_q == CNT_W'(k * STAGGER_TICKS - 1)) rst_d[k] = 1'b0;
        end
        if (cnt_q == REL_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          rst_d   = '0;
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_d = '0;
        if (trig_in || wd_expire || (tick && cnt_q == PERIOD_LAST)) begin
          state_d = ASSERT;
          cnt_d   = '0;
          rst_d   = '1;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
        rst_d   = '1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      cyc_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      cyc_q   <= cyc_d;
      led_q   <= ~|rst_q;
    end
  end

  assign rst_out       = rst_q;
  assign busy_out      = (state_q != RUN);
  assign led_out       = led_q;
  assign cycle_cnt_out = cyc_q;

endmodule

// File: tb/tb_periodic_rst_seq.sv
// tb/tb_periodic_rst_seq.sv - table, directed and randomized checks of periodic_rst_seq
module tb_periodic_rst_seq;

  localparam int P    = 4;
  localparam int PER  = 20;
  localparam int PUL  = 3;
  localparam int NCH  = 2;
  localparam int STG  = 2;
  localparam int TA   = PUL * P;
  localparam int TS   = STG * P;
  localparam int TEND = TA + (NCH - 1) * TS;
  localparam int TRUN = PER * P;
  localparam int WD   = PER / 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic           trig = 1'b0;
  logic           kick = 1'b1;
  logic [NCH-1:0] rst_o;
  logic           busy, led, wdog;
  logic [15:0]    cnt;

  int vectors = 0;
  int errors  = 0;

  periodic_rst_seq #(
    .PRESCALE(P), .PERIOD_TICKS(PER), .PULSE_TICKS(PUL),
    .N_CH(NCH), .STAGGER_TICKS(STG), .CNT_W(32)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .en_in(en), .trig_in(trig), .kick_in(kick),
    .rst_out(rst_o), .busy_out(busy), .led_out(led),
    .cycle_cnt_out(cnt), .wdog_fired_out(wdog)
  );

  always #5 clk = ~clk;

  // Reference: time since sequence start and enabled time spent in RUN.
  bit             m_seq = 1'b1;
  int             m_t = 0, m_run = 0, m_wd = 0, m_cnt = 0;
  logic [NCH-1:0] m_rst = '1;
  bit             m_led = 1'b0, m_wdog = 1'b0;

  task automatic start_seq();
    m_seq = 1'b1;
    m_t   = 0;
    m_rst = '1;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] old;
    bit fire;
    old  = m_rst;
    fire = 1'b0;
    if (!rst_n) begin
      start_seq();
      m_run = 0; m_wd = 0; m_cnt = 0; m_led = 1'b0; m_wdog = 1'b0;
    end else begin
      m_led = ~|old;
      if (m_seq) begin
        m_t++;
        for (int k = 0; k < NCH; k++) m_rst[k] = (m_t < TA + k * TS);
        if (m_t == TEND) begin
          m_seq = 1'b0; m_run = 0; m_wd = 0;
          if (m_cnt < 65535) m_cnt++;
        end
      end else if (trig) begin
        start_seq();
      end else begin
        if (en) m_run++;
`ifdef PERIODIC_RST_WDOG_EN
        if (kick) m_wd = 0;
        else if (en && (m_run % P) == 0) begin
          m_wd++;
          if (m_wd == WD) begin fire = 1'b1; m_wdog = 1'b1; end
        end
`endif
        if (m_run == TRUN) fire = 1'b1;
        if (fire) start_seq();
      end
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic check(string name, logic [NCH-1:0] er, bit eb, bit el, int ec, bit ew);
    vectors++;
    if (rst_o !== er || busy !== eb || led !== el || cnt !== 16'(ec) || wdog !== ew) begin
      errors++;
      $display("FAIL %s: got rst=%b busy=%b led=%b cnt=%0d wdog=%b, expected rst=%b busy=%b led=%b cnt=%0d wdog=%b",
               name, rst_o, busy, led, cnt, wdog, er, eb, el, ec, ew);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Steps until busy equals lvl; n is the number of steps taken (bound on timeout).
  task automatic wait_busy(bit lvl, int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound) begin
      step(1);
      n++;
      if (busy === lvl) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         trig;
    int         n;
    logic [1:0] e_rst;
    bit         e_busy;
    bit         e_led;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n;
  bit   ok;

  initial begin
    tbl.push_back('{1'b0, 1'b1, 1'b0,  3, 2'b11, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 11, 2'b11, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b10, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  7, 2'b10, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b00, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 78, 2'b00, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b11, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b11, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 19, 2'b00, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b1,  1, 2'b11, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b1,  5, 2'b11, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  6, 2'b11, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b10, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  8, 2'b00, 1'b0, 1'b0, 3});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 40, 2'b00, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 30, 2'b00, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 39, 2'b00, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b11, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 2'b10, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 2'b11, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 11, 2'b11, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  1, 2'b10, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0,  8, 2'b00, 1'b0, 1'b0, 1});

    kick = 1'b1;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      trig  = tbl[i].trig;
      step(tbl[i].n);
      check($sformatf("table[%0d]", i), tbl[i].e_rst, tbl[i].e_busy, tbl[i].e_led, tbl[i].e_cnt, 1'b0);
    end

    // Free-running period from RUN entry to ASSERT entry.
    rst_n = 1'b0; en = 1'b1; trig = 1'b0; kick = 1'b1;
    step(2);
    rst_n = 1'b1;
    wait_busy(1'b0, 100, n, ok);
    check_int("first sequence done", int'(ok), 1);
    for (int s = 0; s < 2; s++) begin
      wait_busy(1'b1, 200, n, ok);
      check_int("free-run period", n, TRUN);
      wait_busy(1'b0, 100, n, ok);
      check_int("sequence done", int'(ok), 1);
    end
    check_int("cycle count after 3", int'(cnt), 3);

`ifdef PERIODIC_RST_WDOG_EN
    rst_n = 1'b0; kick = 1'b0;
    step(2);
    rst_n = 1'b1;
    wait_busy(1'b0, 100, n, ok);
    wait_busy(1'b1, 200, n, ok);
    check_int("watchdog delay", n, WD * P);
    check_int("watchdog flag set", int'(wdog), 1);
    rst_n = 1'b0;
    step(1);
    check_int("watchdog flag cleared", int'(wdog), 0);
    step(1);
    rst_n = 1'b1;
    wait_busy(1'b0, 100, n, ok);
    for (int i = 1; i <= 70; i++) begin
      kick = (i % 16 == 0);
      step(1);
    end
    kick = 1'b0;
    check_int("kicked no fire busy", int'(busy), 0);
    check_int("kicked no fire flag", int'(wdog), 0);
`endif

    // Random stimulus against the reference model.
    rst_n = 1'b0; trig = 1'b0;
    step(2);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 7) != 0);
      trig  = ($urandom_range(0, 99) == 0);
      kick  = ($urandom_range(0, 5) == 0);
      step(1);
      check("random", m_rst, m_seq, m_led, m_cnt, m_wdog);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
